// File: rtl/barrel_unrotator.sv
// Elastic right-rotator that undoes the pipelined left barrel shifter; log2(W) rotate steps spread over NUM_STAGES registers.
// Latency NUM_STAGES cycles at 1 word/cycle; a stalled output backs up stage by stage, and in_ready drops only when every stage is full.
module barrel_unrotator #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_STAGES = 1,
    localparam int SA_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [SA_WIDTH-1:0]   in_shift,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [SA_WIDTH-1:0]   out_shift,
    output logic                  busy
);

    localparam int NS         = (NUM_STAGES < 1) ? 1 : NUM_STAGES;
    localparam int STEPS_BASE = SA_WIDTH / NS;
    localparam int STEPS_REM  = SA_WIDTH % NS;

    logic [NS-1:0]         r_vld;
    logic [DATA_WIDTH-1:0] r_dat [NS];
    logic [SA_WIDTH-1:0]   r_sft [NS];

    logic [NS-1:0]         w_adv;
    logic [NS-1:0]         w_up_vld;
    logic [DATA_WIDTH-1:0] w_up_dat [NS];
    logic [SA_WIDTH-1:0]   w_up_sft [NS];
    logic [DATA_WIDTH-1:0] w_rot [NS];

    // Applies the rotate-by-2^k steps numbered lo..hi-1 that are enabled in s.
    function automatic logic [DATA_WIDTH-1:0] f_ror_steps(
        input logic [DATA_WIDTH-1:0] d,
        input logic [SA_WIDTH-1:0]   s,
        input int                    lo,
        input int                    hi
    );
        logic [DATA_WIDTH-1:0] t;
        t = d;
        for (int k = 0; k < SA_WIDTH; k++) begin
            if (k >= lo && k < hi && s[k]) begin
                t = (t >> (2 ** k)) | (t << (DATA_WIDTH - (2 ** k)));
            end
        end
        return t;
    endfunction

    // Stage p may advance unless it and everything downstream is full and the sink stalls.
    always_comb begin
        w_adv = '0;
        for (int p = 0; p < NS; p++) begin
            w_adv[p] = out_ready || !(&(r_vld | NS'((1 << p) - 1)));
        end
    end

    for (genvar p = 0; p < NS; p++) begin : g_stage
        localparam int LO = p * STEPS_BASE + ((p < STEPS_REM) ? p : STEPS_REM);
        localparam int HI = LO + STEPS_BASE + ((p < STEPS_REM) ? 1 : 0);

        if (p == 0) begin : g_head
            assign w_up_vld[p] = in_valid;
            assign w_up_dat[p] = in_data;
            assign w_up_sft[p] = in_shift;
        end else begin : g_body
            assign w_up_vld[p] = r_vld[p-1];
            assign w_up_dat[p] = r_dat[p-1];
            assign w_up_sft[p] = r_sft[p-1];
        end

        assign w_rot[p] = f_ror_steps(w_up_dat[p], w_up_sft[p], LO, HI);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld <= '0;
            for (int p = 0; p < NS; p++) begin
                r_dat[p] <= '0;
                r_sft[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NS; p++) begin
                if (w_adv[p]) begin
                    r_vld[p] <= w_up_vld[p];
                    if (w_up_vld[p]) begin
                        r_dat[p] <= w_rot[p];
                        r_sft[p] <= w_up_sft[p];
                    end
                end
            end
        end
    end

    assign in_ready  = w_adv[0];
    assign out_valid = r_vld[NS-1];
    assign out_data  = r_dat[NS-1];
    assign out_shift = r_sft[NS-1];
    assign busy      = |r_vld;

endmodule

// File: tb/tb_barrel_unrotator.sv
// Bench for barrel_unrotator: directed cases on W=32 instances, random round-trip traffic on W=8/W=64 instances.
module tb_barrel_unrotator;

    logic clk;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;

    // Directed-instance controls (instances 0..2, all W=32) and their observed outputs.
    logic        d_rst [3];
    logic        d_vld [3];
    logic        d_rdy [3];
    logic [31:0] d_dat [3];
    logic [4:0]  d_sft [3];
    logic        m_ovld [3];
    logic        m_irdy [3];
    logic        m_busy [3];
    logic [31:0] m_odat [3];
    logic [4:0]  m_osft [3];

    function automatic logic [63:0] ror(input logic [63:0] d, input int s, input int w);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < w; i++) r[i] = d[(i + s) % w];
        return r;
    endfunction

    function automatic logic [63:0] rol(input logic [63:0] d, input int s, input int w);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < w; i++) r[(i + s) % w] = d[i];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30) $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int cfg_w(input int i);
        return (i < 3) ? 32 : ((i < 8) ? 8 : 64);
    endfunction

    function automatic int cfg_n(input int i);
        case (i)
            0: return 1;  1: return 3;  2: return 2;
            3: return 0;  4: return 1;  5: return 2;  6: return 3;  7: return 5;
            8: return 0;  9: return 1;  10: return 2; 11: return 6; default: return 8;
        endcase
    endfunction

    for (genvar gi = 0; gi < 13; gi++) begin : g
        localparam int W  = cfg_w(gi);
        localparam int N  = cfg_n(gi);
        localparam int NS = (N < 1) ? 1 : N;
        localparam int SA = $clog2(W);

        logic          rst, vld, rdy, irdy, ovld, busy;
        logic [W-1:0]  dat, odat, golden, h_dat;
        logic [SA-1:0] sft, osft, h_sft;
        logic [W+SA-1:0] q [$];
        logic [W+SA-1:0] e;
        logic          acc = 1'b0;
        logic          stalled = 1'b0;
        int            delivered = 0;

        barrel_unrotator #(.DATA_WIDTH(W), .NUM_STAGES(N)) dut (
            .clk(clk), .reset(rst), .in_valid(vld), .in_ready(irdy),
            .in_data(dat), .in_shift(sft), .out_valid(ovld), .out_ready(rdy),
            .out_data(odat), .out_shift(osft), .busy(busy)
        );

        if (gi < 3) begin : dir
            logic [63:0] g64;
            assign rst = d_rst[gi];
            assign vld = d_vld[gi];
            assign rdy = d_rdy[gi];
            assign dat = d_dat[gi];
            assign sft = d_sft[gi];
            assign g64 = ror(64'(dat), int'(sft), W);
            assign golden = g64[W-1:0];
            assign m_ovld[gi] = ovld;
            assign m_irdy[gi] = irdy;
            assign m_busy[gi] = busy;
            assign m_odat[gi] = odat;
            assign m_osft[gi] = osft;
        end else begin : rnd
            logic [63:0] r64, t64;
            int s, sent, guard, pat;
            initial begin
                rst = 1'b1; vld = 1'b0; rdy = 1'b0; dat = '0; sft = '0; golden = '0;
                sent = 0; guard = 0;
                repeat (3) @(negedge clk);
                rst = 1'b0;
                while (1) begin
                    if (acc) sent++;
                    if (sent >= 2000 || guard >= 40000) break;
                    if (acc || !vld) begin
                        pat = $urandom_range(0, 15);
                        r64 = {$urandom(), $urandom()};
                        if (pat == 0) r64 = '0;
                        if (pat == 1) r64 = '1;
                        s = $urandom_range(0, W - 1);
                        golden = r64[W-1:0];
                        t64 = rol(64'(golden), s, W);
                        dat = t64[W-1:0];
                        sft = SA'(s);
                    end
                    vld = ($urandom_range(0, 3) != 0);
                    rdy = ($urandom_range(0, 3) != 0);
                    @(negedge clk);
                    guard++;
                end
                vld = 1'b0;
                rdy = 1'b1;
                guard = 0;
                while (q.size() != 0 && guard < 200) begin
                    @(negedge clk);
                    guard++;
                end
                @(negedge clk);
                #3;
                chk($sformatf("g%0d words sent", gi), 64'(sent), 64'd2000);
                chk($sformatf("g%0d words delivered", gi), 64'(delivered), 64'd2000);
                chk($sformatf("g%0d left in flight", gi), 64'(q.size()), 64'd0);
                n_done++;
            end
        end

        // Occupancy model: the queue holds every accepted word not yet delivered.
        always @(negedge clk) begin
            #2;
            if (rst) begin
                q.delete();
                stalled = 1'b0;
                acc = 1'b0;
            end else begin
                chk($sformatf("g%0d busy", gi), 64'(busy), 64'(q.size() != 0));
                chk($sformatf("g%0d in_ready", gi), 64'(irdy), 64'(!(q.size() == NS && !rdy)));
                if (stalled) begin
                    chk($sformatf("g%0d held valid", gi), 64'(ovld), 64'd1);
                    chk($sformatf("g%0d held data", gi), 64'(odat), 64'(h_dat));
                    chk($sformatf("g%0d held shift", gi), 64'(osft), 64'(h_sft));
                end
                if (ovld && rdy) begin
                    if (q.size() == 0) begin
                        chk($sformatf("g%0d unexpected word", gi), 64'(ovld), 64'd0);
                    end else begin
                        e = q.pop_front();
                        chk($sformatf("g%0d out_data", gi), 64'(odat), 64'(e[W-1:0]));
                        chk($sformatf("g%0d out_shift", gi), 64'(osft), 64'(e[W+SA-1:W]));
                        delivered++;
                    end
                end
                acc = vld && irdy;
                if (acc) q.push_back({sft, golden});
                stalled = ovld && !rdy;
                h_dat = odat;
                h_sft = osft;
            end
        end
    end

    logic [31:0] t2_in [3];
    int          t2_s  [3];
    logic [31:0] t2_exp[3];
    logic [31:0] tw    [10];
    int          ts    [10];
    logic [31:0] hold;
    int acc_n, del_n, guard;

    initial begin
        for (int k = 0; k < 3; k++) begin
            d_rst[k] = 1'b1; d_vld[k] = 1'b1; d_rdy[k] = 1'b1;
            d_dat[k] = 32'hA5A5_A5A5 ^ 32'(k);
            d_sft[k] = 5'(k + 3);
        end
        t2_in  = '{32'h8000_0001, 32'h0000_0001, 32'hDEAD_BEEF};
        t2_s   = '{1, 31, 0};
        t2_exp = '{32'hC000_0000, 32'h0000_0002, 32'hDEAD_BEEF};

        chk("model ror 32/1", ror(64'h8000_0001, 1, 32), 64'hC000_0000);
        chk("model ror 32/31", ror(64'h1, 31, 32), 64'h2);
        chk("model ror 8/3", ror(64'hB4, 3, 8), 64'h96);
        chk("model rol 64/4", rol(64'hF000_0000_0000_0001, 4, 64), 64'h0000_0000_0000_001F);

        // T1: reset held two cycles with in_valid high
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            d_rst[k] = 1'b0;
            d_vld[k] = 1'b0;
        end
        #2;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("T1 out_valid[%0d]", k), 64'(m_ovld[k]), 64'd0);
            chk($sformatf("T1 out_data[%0d]", k), 64'(m_odat[k]), 64'd0);
            chk($sformatf("T1 out_shift[%0d]", k), 64'(m_osft[k]), 64'd0);
            chk($sformatf("T1 busy[%0d]", k), 64'(m_busy[k]), 64'd0);
            chk($sformatf("T1 in_ready[%0d]", k), 64'(m_irdy[k]), 64'd1);
        end
        repeat (4) begin
            @(negedge clk);
            #2;
            for (int k = 0; k < 3; k++) chk($sformatf("T1 quiet[%0d]", k), 64'(m_ovld[k]), 64'd0);
        end

        // T2: single stage, one-cycle latency
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k < 3) begin
                d_vld[0] = 1'b1; d_dat[0] = t2_in[k]; d_sft[0] = 5'(t2_s[k]);
            end else begin
                d_vld[0] = 1'b0;
            end
            #2;
            if (k >= 1 && k <= 3) begin
                chk("T2 out_valid", 64'(m_ovld[0]), 64'd1);
                chk("T2 out_data", 64'(m_odat[0]), 64'(t2_exp[k-1]));
                chk("T2 out_shift", 64'(m_osft[0]), 64'(t2_s[k-1]));
            end else begin
                chk("T2 idle", 64'(m_ovld[0]), 64'd0);
            end
        end

        // T3: three stages, eight back-to-back words
        for (int k = 0; k < 10; k++) begin
            tw[k] = 32'h9E37_79B9 * 32'(k + 1);
            ts[k] = (k * 7 + 1) % 32;
        end
        for (int t = 0; t < 13; t++) begin
            @(negedge clk);
            if (t < 8) begin
                d_vld[1] = 1'b1; d_dat[1] = tw[t]; d_sft[1] = 5'(ts[t]);
            end else begin
                d_vld[1] = 1'b0;
            end
            #2;
            if (t < 8) chk("T3 in_ready", 64'(m_irdy[1]), 64'd1);
            chk("T3 out_valid", 64'(m_ovld[1]), 64'(t >= 3 && t < 11));
            if (t >= 3 && t < 11) chk("T3 out_data", 64'(m_odat[1]), ror(64'(tw[t-3]), ts[t-3], 32));
        end

        // T4: stall for six cycles, then release
        for (int k = 0; k < 10; k++) begin
            tw[k] = 32'h0F1E_2D3C ^ (32'h0101_0101 * 32'(k + 1));
            ts[k] = (k * 3 + 2) % 32;
        end
        acc_n = 0;
        hold = '0;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            d_rdy[1] = 1'b0; d_vld[1] = 1'b1;
            d_dat[1] = tw[acc_n]; d_sft[1] = 5'(ts[acc_n]);
            #2;
            if (m_irdy[1]) acc_n++;
            if (t == 3) hold = m_odat[1];
        end
        chk("T4 accepted while stalled", 64'(acc_n), 64'd3);
        chk("T4 in_ready full", 64'(m_irdy[1]), 64'd0);
        chk("T4 out_valid held", 64'(m_ovld[1]), 64'd1);
        chk("T4 head word", 64'(m_odat[1]), ror(64'(tw[0]), ts[0], 32));
        chk("T4 out_data stable", 64'(m_odat[1]), 64'(hold));
        del_n = 0;
        guard = 0;
        while (del_n < 10 && guard < 60) begin
            @(negedge clk);
            guard++;
            d_rdy[1] = 1'b1;
            d_vld[1] = (acc_n < 10);
            if (acc_n < 10) begin
                d_dat[1] = tw[acc_n]; d_sft[1] = 5'(ts[acc_n]);
            end
            #2;
            if (m_ovld[1]) begin
                chk("T4 drained word", 64'(m_odat[1]), ror(64'(tw[del_n]), ts[del_n], 32));
                del_n++;
            end
            if (d_vld[1] && m_irdy[1]) acc_n++;
        end
        d_vld[1] = 1'b0;
        chk("T4 total accepted", 64'(acc_n), 64'd10);
        chk("T4 total delivered", 64'(del_n), 64'd10);

        // T5: reset with two words in flight
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            d_rdy[2] = 1'b0; d_vld[2] = 1'b1;
            d_dat[2] = 32'h1357_9BDF + 32'(t); d_sft[2] = 5'(t + 9);
        end
        @(negedge clk);
        #2;
        chk("T5 two in flight", 64'(m_busy[2] && m_ovld[2] && !m_irdy[2]), 64'd1);
        d_rst[2] = 1'b1; d_dat[2] = 32'hFFFF_0000;
        @(negedge clk);
        d_rst[2] = 1'b0; d_vld[2] = 1'b0; d_rdy[2] = 1'b1;
        #2;
        chk("T5 out_valid after reset", 64'(m_ovld[2]), 64'd0);
        chk("T5 busy after reset", 64'(m_busy[2]), 64'd0);
        repeat (5) begin
            @(negedge clk);
            #2;
            chk("T5 flushed stays gone", 64'(m_ovld[2]), 64'd0);
        end

        guard = 0;
        while (n_done < 10 && guard < 60000) begin
            @(negedge clk);
            guard++;
        end
        chk("random instances finished", 64'(n_done), 64'd10);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
